ahb_arbiter: RTL and testbench

- Four-master AHB bus arbiter with burst-aware, round-robin grant handover.
- Sits between the master request lines and the AHB master-to-slave multiplexer.
- Drives a one-hot grant vector, plus the encoded owner index used to steer the address/control mux.
- Keeps the grant for the full length of a defined-length burst before handing over.

---
 rtl/ahb_arbiter.sv | 167 ++++++++++++++++
 tb/tb_ahb_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ahb_arbiter.sv
// Four-master AHB arbiter with burst-aware round-robin grant handover.
// The grant is held for the whole length of a defined-length burst. Undefined-length
// INCR bursts are forced to re-arbitrate after INCR_MAX_BEATS accepted beats.
// Optional macro AHB_ARB_FIXED_PRIORITY_EN switches every arbitration point to
// fixed priority (master 0 highest). Burst locking and parking are unchanged.
module ahb_arbiter #(
    parameter int DEFAULT_MASTER = 0,
    parameter int INCR_MAX_BEATS = 16
) (
    input  logic       Hclk,
    input  logic       Hresetn,
    input  logic [3:0] Hreq,
    input  logic       Hready,
    input  logic [1:0] Htrans,
    input  logic [2:0] Hburst,
    output logic [3:0] Hgrant,
    output logic [1:0] Hmaster
);

    localparam logic [1:0] DEF_IDX    = 2'(DEFAULT_MASTER);
    localparam logic [3:0] DEF_GRANT  = 4'b0001 << DEFAULT_MASTER;
    localparam logic [7:0] INCR_LIMIT = 8'(INCR_MAX_BEATS);

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;

    typedef enum logic {ST_ARB, ST_BURST} state_t;

    state_t     r_state;
    logic [1:0] r_owner;
    logic [3:0] r_grant;
    logic [7:0] r_count;
    logic [7:0] r_len;      // beat count at which the locked burst ends
    logic       r_incr;     // locked burst is undefined-length INCR

    state_t     w_state_next;
    logic [1:0] w_owner_next;
    logic [3:0] w_grant_next;
    logic [7:0] w_count_next;
    logic [7:0] w_len_next;
    logic       w_incr_next;

    logic       w_accept;
    logic       w_nonseq;
    logic [7:0] w_len_dec;
    logic       w_incr_dec;
    logic [7:0] w_count_beat;
    logic [7:0] w_len_eff;
    logic       w_incr_eff;
    logic       w_handover;
    logic [1:0] w_sel_idx;
    logic       w_sel_valid;

    // INCR uses the anti-starvation limit as its effective length
    function automatic logic [7:0] burst_len(input logic [2:0] burst);
        case (burst)
            3'b000:         return 8'd1;
            3'b001:         return INCR_LIMIT;
            3'b010, 3'b011: return 8'd4;
            3'b100, 3'b101: return 8'd8;
            default:        return 8'd16;
        endcase
    endfunction

    assign w_accept     = Hready && Htrans[1];
    assign w_nonseq     = w_accept && (Htrans == TR_NONSEQ);
    assign w_len_dec    = burst_len(Hburst);
    assign w_incr_dec   = (Hburst == 3'b001);
    assign w_count_beat = w_nonseq ? 8'd1 : (w_accept ? r_count + 8'd1 : r_count);
    assign w_len_eff    = w_nonseq ? w_len_dec : r_len;
    assign w_incr_eff   = w_nonseq ? w_incr_dec : r_incr;
    assign w_sel_valid  = |Hreq;

    // Burst end, INCR idle, or owner idling with its request dropped
    assign w_handover = (w_accept && (w_count_beat == w_len_eff))
                     || (w_incr_eff && (Htrans == TR_IDLE))
                     || ((Htrans == TR_IDLE) && !Hreq[r_owner]);

`ifdef AHB_ARB_FIXED_PRIORITY_EN
    // Lowest-numbered requester wins; owner kept when nobody requests
    always_comb begin
        w_sel_idx = r_owner;
        for (int k = 3; k >= 0; k--) begin
            if (Hreq[k]) w_sel_idx = 2'(k);
        end
    end
`else
    logic [1:0] w_cand_idx [4];
    logic [3:0] w_cand_req;

    // Candidate k is owner+k+1 (mod 4), so the owner itself is searched last
    for (genvar gi = 0; gi < 4; gi++) begin : g_cand
        assign w_cand_idx[gi] = r_owner + 2'(gi + 1);
        assign w_cand_req[gi] = Hreq[w_cand_idx[gi]];
    end

    // First requesting candidate in round-robin order wins
    always_comb begin
        w_sel_idx = r_owner;
        for (int k = 3; k >= 0; k--) begin
            if (w_cand_req[k]) w_sel_idx = w_cand_idx[k];
        end
    end
`endif

    // Next-state and next-grant; Hready=0 freezes everything
    always_comb begin
        w_state_next = r_state;
        w_owner_next = r_owner;
        w_grant_next = r_grant;
        w_count_next = r_count;
        w_len_next   = r_len;
        w_incr_next  = r_incr;
        if (Hready) begin
            if (w_nonseq) begin
                w_len_next  = w_len_dec;
                w_incr_next = w_incr_dec;
            end
            case (r_state)
                ST_ARB: begin
                    w_count_next = w_count_beat;
                    if (w_nonseq && (w_len_dec > 8'd1)) begin
                        w_state_next = ST_BURST;
                    end else if (w_sel_valid && (w_sel_idx != r_owner)) begin
                        w_owner_next = w_sel_idx;
                        w_grant_next = 4'b0001 << w_sel_idx;
                        w_count_next = 8'd0;
                    end
                end
                default: begin
                    w_count_next = w_count_beat;
                    if (w_handover) begin
                        w_state_next = ST_ARB;
                        w_count_next = 8'd0;
                        if (w_sel_valid) begin
                            w_owner_next = w_sel_idx;
                            w_grant_next = 4'b0001 << w_sel_idx;
                        end
                    end
                end
            endcase
        end
    end

    // State register with asynchronous active-low reset
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            r_state <= ST_ARB;
            r_owner <= DEF_IDX;
            r_grant <= DEF_GRANT;
            r_count <= 8'd0;
            r_len   <= 8'd1;
            r_incr  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_owner <= w_owner_next;
            r_grant <= w_grant_next;
            r_count <= w_count_next;
            r_len   <= w_len_next;
            r_incr  <= w_incr_next;
        end
    end

    assign Hgrant  = r_grant;
    assign Hmaster = r_owner;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Testbench for ahb_arbiter: directed test-plan scenarios followed by
// randomized traffic, all checked against a transaction-level reference model.
module tb_ahb_arbiter;

    localparam int INCR_MAX = 16;

    logic       Hclk;
    logic       Hresetn;
    logic [3:0] Hreq;
    logic       Hready;
    logic [1:0] Htrans;
    logic [2:0] Hburst;
    logic [3:0] Hgrant;
    logic [1:0] Hmaster;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: who owns the bus, whether a burst holds it, progress
    int m_owner;
    bit m_locked;
    int m_beats;
    int m_limit;
    bit m_incr;

    ahb_arbiter #(.DEFAULT_MASTER(0), .INCR_MAX_BEATS(INCR_MAX)) dut (
        .Hclk    (Hclk),
        .Hresetn (Hresetn),
        .Hreq    (Hreq),
        .Hready  (Hready),
        .Htrans  (Htrans),
        .Hburst  (Hburst),
        .Hgrant  (Hgrant),
        .Hmaster (Hmaster)
    );

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Next owner per arbitration rules; -1 means nobody requests (park)
    function automatic int pick(input int owner, input logic [3:0] req);
`ifdef AHB_ARB_FIXED_PRIORITY_EN
        for (int k = 0; k < 4; k++) if (req[k]) return k;
`else
        for (int k = 1; k <= 4; k++) if (req[(owner + k) % 4]) return (owner + k) % 4;
`endif
        return -1;
    endfunction

    function automatic int blen(input logic [2:0] b);
        case (b)
            3'd0: return 1;
            3'd1: return INCR_MAX;
            3'd2, 3'd3: return 4;
            3'd4, 3'd5: return 8;
            default: return 16;
        endcase
    endfunction

    function automatic void model_reset();
        m_owner = 0; m_locked = 0; m_beats = 0; m_limit = 1; m_incr = 0;
    endfunction

    // One bus edge expressed as a transaction on the model
    function automatic void model_edge(input logic [3:0] req, input logic rdy,
                                       input logic [1:0] tr, input logic [2:0] bu);
        bit acc, ns, idle, done;
        int w;
        if (!rdy) return;
        acc  = (tr == 2'b10) || (tr == 2'b11);
        ns   = (tr == 2'b10);
        idle = (tr == 2'b00);
        if (ns) begin
            m_beats = 1;
            m_limit = blen(bu);
            m_incr  = (bu == 3'd1);
        end else if (acc) begin
            m_beats++;
        end
        if (!m_locked) begin
            if (ns && m_limit > 1) begin
                m_locked = 1;
            end else begin
                w = pick(m_owner, req);
                if (w >= 0 && w != m_owner) begin
                    m_owner = w;
                    m_beats = 0;
                end
            end
        end else begin
            done = (acc && m_beats == m_limit) || (m_incr && idle) || (idle && !req[m_owner]);
            if (done) begin
                w = pick(m_owner, req);
                if (w >= 0) m_owner = w;
                m_beats  = 0;
                m_locked = 0;
            end
        end
    endfunction

    task automatic step(input logic [3:0] req, input logic rdy,
                        input logic [1:0] tr, input logic [2:0] bu);
        logic [3:0] exp_grant;
        @(negedge Hclk);
        Hreq = req; Hready = rdy; Htrans = tr; Hburst = bu;
        model_edge(req, rdy, tr, bu);
        @(posedge Hclk);
        #1;
        exp_grant = 4'b0001 << m_owner;
        check("hgrant", 32'(Hgrant), 32'(exp_grant));
        check("hmaster", 32'(Hmaster), 32'(m_owner));
        $display("t=%0t req=%b rdy=%b trans=%b burst=%b -> grant=%b master=%0d (model %0d)",
                 $time, req, rdy, tr, bu, Hgrant, Hmaster, m_owner);
    endtask

    task automatic do_reset(input int cycles);
        Hresetn = 1'b0;
        Hreq = 4'b0000; Hready = 1'b1; Htrans = 2'b00; Hburst = 3'b000;
        model_reset();
        repeat (cycles) @(posedge Hclk);
        #1;
        check("reset_grant", 32'(Hgrant), 32'h1);
        check("reset_master", 32'(Hmaster), 32'h0);
        @(negedge Hclk);
        Hresetn = 1'b1;
    endtask

    localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NSQ = 2'b10, SEQ = 2'b11;

    initial begin
        Hresetn = 1'b0;
        Hreq = 4'b0000; Hready = 1'b1; Htrans = IDLE; Hburst = 3'b000;
        model_reset();

        // Reset, then parked with no requests
        do_reset(3);
        step(4'b0000, 1, IDLE, 3'b000);
        step(4'b0000, 1, IDLE, 3'b000);

        // INCR4 bursts from each master in turn, wrapping back to master 0
        for (int m = 0; m < 4; m++) begin
            step(4'b1111, 1, NSQ, 3'b011);
            for (int b = 0; b < 3; b++) step(4'b1111, 1, SEQ, 3'b011);
        end
        check("rr_wrap", 32'(Hgrant), 32'h1);

        // Master 1 INCR8 with two wait states mid-burst
        step(4'b0010, 1, IDLE, 3'b000);
        step(4'b1111, 1, NSQ, 3'b101);
        for (int b = 0; b < 3; b++) step(4'b1111, 1, SEQ, 3'b101);
        step(4'b1111, 0, SEQ, 3'b101);
        step(4'b1111, 0, SEQ, 3'b101);
        for (int b = 0; b < 3; b++) step(4'b1111, 1, SEQ, 3'b101);
        check("incr8_hold", 32'(Hgrant), 32'h2);
        step(4'b1111, 1, SEQ, 3'b101);
        check("incr8_release", 32'(Hgrant), 32'h4);

        // Sole requester master 2 with SINGLE transfers
        step(4'b0001, 1, IDLE, 3'b000);
        step(4'b0100, 1, IDLE, 3'b000);
        for (int b = 0; b < 3; b++) step(4'b0100, 1, NSQ, 3'b000);
        check("sole_req", 32'(Hgrant), 32'h4);

        // INCR forced handover after the beat limit
        step(4'b1111, 1, NSQ, 3'b001);
        for (int b = 0; b < INCR_MAX - 1; b++) step(4'b1111, 1, SEQ, 3'b001);
        check("incr_limit", 32'(Hgrant), 32'h8);

        // INCR ended early by IDLE
        step(4'b1111, 1, NSQ, 3'b001);
        step(4'b1111, 1, SEQ, 3'b001);
        step(4'b1111, 1, SEQ, 3'b001);
        step(4'b1111, 1, IDLE, 3'b001);
        check("incr_idle", 32'(Hgrant), 32'h1);

        // Defined burst terminated by IDLE with own request dropped; BUSY holds
        step(4'b1111, 1, NSQ, 3'b011);
        step(4'b1111, 1, BUSY, 3'b011);
        step(4'b1110, 1, SEQ, 3'b011);
        step(4'b1110, 1, IDLE, 3'b011);
        check("early_term", 32'(Hgrant), 32'h2);

        // Reset asserted mid-burst acts immediately
        step(4'b1111, 1, NSQ, 3'b101);
        step(4'b1111, 1, SEQ, 3'b101);
        #2;
        Hresetn = 1'b0;
        #1;
        check("async_reset_grant", 32'(Hgrant), 32'h1);
        check("async_reset_master", 32'(Hmaster), 32'h0);
        do_reset(2);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            logic [3:0] rq;
            logic       rd;
            logic [1:0] tr;
            int         r;
            rq = 4'($urandom_range(0, 15));
            rd = ($urandom_range(0, 3) != 0);
            r  = $urandom_range(0, 9);
            tr = (r < 2) ? IDLE : (r == 2) ? BUSY : (r < 6) ? NSQ : SEQ;
            step(rq, rd, tr, 3'($urandom_range(0, 7)));
            check("onehot", 32'($countones(Hgrant)), 32'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
